trinary_unit_scheduler: RTL and testbench

Shares one NeutralTrinaryUnit between NUM_REQ requesters and sequences it for each request. It picks requesters in round-robin order and forwards already-stable states straight back. For unstable states it pulses the unit's start, waits a fixed resolve window, samples the result, and retries up to MAX_RETRY times. It sits between requester logic and the unit's start_process / initial_state / resolved_state pins.

---
 rtl/trinary_pkg.sv | 19 +
 rtl/trinary_unit_scheduler_rr_arbiter.sv | 28 ++
 rtl/trinary_unit_scheduler.sv | 146 ++++++++++++++
 tb/tb_trinary_unit_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trinary_pkg.sv
// Shared types for the NeutralTrinaryUnit scheduler: trit encoding and FSM states.
package trinary_pkg;

  typedef enum logic [1:0] {
    NEG      = 2'b00,
    NEUTRAL  = 2'b01,
    UNSTABLE = 2'b10,
    POS      = 2'b11
  } trit_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_RESPOND
  } sched_state_t;

endpackage

// File: rtl/trinary_unit_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester after last_grant_i.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_grant_i,
  output logic [N-1:0]         grant_o
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last_grant_i) + i) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trinary_unit_scheduler.sv
// Shares one NeutralTrinaryUnit between NUM_REQ requesters: round-robin pick,
// stable trits bypass the unit, unstable trits are resolved with bounded retries.
module trinary_unit_scheduler
  import trinary_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int RESOLVE_CYCLES = 4,
  parameter int MAX_RETRY      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_state,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [1:0]           rsp_state,
  output logic                 rsp_error,
  output logic                 ntu_start,
  output logic [1:0]           ntu_init,
  input  logic [1:0]           ntu_result,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(RESOLVE_CYCLES + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  sched_state_t  state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] id_q, id_d;
  trit_t         lat_q, lat_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [WW-1:0] wait_q, wait_d;
  trit_t         rsp_state_q, rsp_state_d;
  logic          rsp_error_q, rsp_error_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gnt_id;
  trit_t              sel_state;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );

  // Grant is only offered in IDLE and never while reset is being applied.
  assign req_ready = (rst && state_q == S_IDLE) ? grant : '0;

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_id = IW'(i);
    end
  end

  assign sel_state = trit_t'(req_state[2*int'(gnt_id) +: 2]);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    lat_d       = lat_q;
    retry_d     = retry_q;
    wait_d      = wait_q;
    rsp_state_d = rsp_state_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      S_IDLE: begin
        if (|req_ready) begin
          id_d    = gnt_id;
          lat_d   = sel_state;
          retry_d = '0;
          if (sel_state != UNSTABLE) begin
            rsp_state_d = sel_state;
            rsp_error_d = 1'b0;
            state_d     = S_RESPOND;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wait_d  = WW'(RESOLVE_CYCLES);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q <= WW'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (trit_t'(ntu_result) != UNSTABLE) begin
          rsp_state_d = trit_t'(ntu_result);
          rsp_error_d = 1'b0;
          state_d     = S_RESPOND;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = S_ISSUE;
        end else begin
          rsp_state_d = UNSTABLE;
          rsp_error_d = 1'b1;
          state_d     = S_RESPOND;
        end
      end
      S_RESPOND: begin
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      last_q      <= IW'(NUM_REQ - 1);
      id_q        <= '0;
      lat_q       <= NEG;
      retry_q     <= '0;
      wait_q      <= '0;
      rsp_state_q <= NEG;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      lat_q       <= lat_d;
      retry_q     <= retry_d;
      wait_q      <= wait_d;
      rsp_state_q <= rsp_state_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESPOND) rsp_valid[id_q] = 1'b1;
  end

  assign busy      = (state_q != S_IDLE);
  assign ntu_start = (state_q == S_ISSUE);
  assign ntu_init  = (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_CHECK) ? lat_q : 2'b00;
  assign rsp_state = rsp_state_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_trinary_unit_scheduler.sv
// Bench for trinary_unit_scheduler: vector table plus hand-written corner sequences,
// responses checked against a scoreboard queue; behavioural unit with tunable result/latency.
module tb_trinary_unit_scheduler;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int MR = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_state;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [1:0]     rsp_state;
  logic           rsp_error;
  logic           ntu_start;
  logic [1:0]     ntu_init;
  logic [1:0]     ntu_result;
  logic           busy;

  trinary_unit_scheduler #(.NUM_REQ(N), .RESOLVE_CYCLES(R), .MAX_RETRY(MR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_state  (req_state),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_state  (rsp_state),
    .rsp_error  (rsp_error),
    .ntu_start  (ntu_start),
    .ntu_init   (ntu_init),
    .ntu_result (ntu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Unit model: attempts below m_fail never resolve; otherwise m_val appears m_lat cycles after start.
  logic [1:0] m_val  = 2'b11;
  int         m_lat  = 0;
  int         m_fail = 0;
  int         m_att  = 0;
  int         m_cnt  = 0;
  logic [1:0] m_res  = 2'b10;
  assign ntu_result = m_res;

  always @(posedge clk) begin
    if (!rst || |rsp_valid) m_att <= 0;
    if (ntu_start) begin
      m_att <= m_att + 1;
      if (m_att < m_fail) begin
        m_res <= 2'b10;
        m_cnt <= 0;
      end else if (m_lat == 0) begin
        m_res <= m_val;
        m_cnt <= 0;
      end else begin
        m_res <= 2'b10;
        m_cnt <= m_lat;
      end
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_res <= m_val;
      m_cnt <= 0;
    end
  end

  typedef struct {
    int         id;
    logic [1:0] st;
    logic       err;
    int         due;
    int         starts;
  } sb_t;

  sb_t q[$];

  task automatic push(input int id, input logic [1:0] st, input logic err, input int due, input int starts);
    sb_t e;
    e.id = id; e.st = st; e.err = err; e.due = due; e.starts = starts;
    q.push_back(e);
  endtask

  int start_cnt  = 0;
  int last_start = 0;

  always @(negedge clk) begin
    if (!rst) begin
      start_cnt = 0;
    end else begin
      if (ntu_start) begin
        start_cnt++;
        chk("ntu_init_at_start", 32'(ntu_init), 32'h2);
        if (start_cnt > 1) chk("start_spacing", 32'(cyc - last_start), 32'(R + 2));
        last_start = cyc;
      end
      if (rsp_valid != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
        end else begin
          sb_t e;
          e = q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.id));
          chk("rsp_state", 32'(rsp_state), 32'(e.st));
          chk("rsp_error", 32'(rsp_error), 32'(e.err));
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
          chk("start_count", 32'(start_cnt), 32'(e.starts));
        end
        start_cnt = 0;
      end
      chk("invariants", {29'd0, $onehot0(rsp_valid), $onehot0(req_ready),
                         !(|rsp_valid && |req_ready)}, 32'h7);
    end
  end

  typedef struct {
    int         id;
    logic [1:0] st;
    logic [1:0] mval;
    int         mlat;
    int         mfail;
    logic [1:0] exp_st;
    logic       exp_err;
    int         exp_lat;
    int         exp_starts;
  } vec_t;

  vec_t tbl[9];

  task automatic wait_grant(output int gcyc, output logic found);
    found = 1'b0;
    gcyc  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        found = 1'b1;
        gcyc  = cyc;
        break;
      end
    end
    if (!found) chk("grant_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'h0);
  endtask

  task automatic run_vec(input vec_t v);
    int   g;
    logic f;
    m_val  = v.mval;
    m_lat  = v.mlat;
    m_fail = v.mfail;
    @(posedge clk);
    #1;
    req_state[2*v.id +: 2] = v.st;
    req_valid[v.id] = 1'b1;
    wait_grant(g, f);
    if (f) begin
      chk("tbl_grant", 32'(req_ready), 32'(1 << v.id));
      push(v.id, v.exp_st, v.exp_err, g + v.exp_lat, v.exp_starts);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();
  endtask

  initial begin
    int   g;
    int   t0;
    logic f;
    int   rr_ord[4];

    //         id  st     mval   lat fail  exp_st exp_err lat starts
    tbl[0] = '{2, 2'b01, 2'b11, 0, 0, 2'b01, 1'b0, 1,  0};
    tbl[1] = '{0, 2'b10, 2'b11, 2, 0, 2'b11, 1'b0, 7,  1};
    tbl[2] = '{1, 2'b10, 2'b10, 1, 0, 2'b10, 1'b1, 19, 3};
    tbl[3] = '{3, 2'b10, 2'b00, 4, 0, 2'b00, 1'b0, 7,  1};
    tbl[4] = '{0, 2'b10, 2'b01, 5, 0, 2'b10, 1'b1, 19, 3};
    tbl[5] = '{2, 2'b10, 2'b11, 1, 1, 2'b11, 1'b0, 13, 2};
    tbl[6] = '{1, 2'b11, 2'b00, 0, 0, 2'b11, 1'b0, 1,  0};
    tbl[7] = '{3, 2'b00, 2'b11, 0, 0, 2'b00, 1'b0, 1,  0};
    tbl[8] = '{0, 2'b10, 2'b11, 0, 2, 2'b11, 1'b0, 19, 3};
    rr_ord = '{0, 1, 3, 0};

    rst       = 1'b0;
    req_valid = '0;
    req_state = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {18'd0, busy, ntu_start, ntu_init, rsp_valid, req_ready, rsp_state, rsp_error}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Round-robin after reset: requesters 0, 1, 3 held valid with bypass trits.
    req_state = '0;
    req_valid = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, f);
      if (f) begin
        chk("rr_grant", 32'(req_ready), 32'(1 << rr_ord[k]));
        push(rr_ord[k], 2'b00, 1'b0, g + 1, 0);
      end
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    foreach (tbl[i]) run_vec(tbl[i]);

    // Busy hold: requester 1 arrives while requester 0 is in its resolve window.
    m_val = 2'b11; m_lat = 2; m_fail = 0;
    @(posedge clk);
    #1;
    req_state[1:0] = 2'b10;
    req_valid[0]   = 1'b1;
    wait_grant(t0, f);
    if (f) push(0, 2'b11, 1'b0, t0 + 7, 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    req_state[3:2] = 2'b01;
    req_valid[1]   = 1'b1;
    wait_grant(g, f);
    if (f) begin
      chk("hold_grant_cycle", 32'(g), 32'(t0 + 8));
      chk("hold_grant", 32'(req_ready), 32'h2);
      push(1, 2'b01, 1'b0, g + 1, 0);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    // Reset during WAIT: transaction vanishes, priority returns to requester 0.
    @(posedge clk);
    #1;
    req_state[7:6] = 2'b10;
    req_valid[3]   = 1'b1;
    wait_grant(g, f);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_wait_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_outputs", {18'd0, busy, ntu_start, ntu_init, rsp_valid, req_ready, rsp_state, rsp_error}, 32'h0);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1;
    req_state      = '0;
    req_state[1:0] = 2'b01;
    req_state[5:4] = 2'b01;
    req_valid      = 4'b0101;
    wait_grant(g, f);
    if (f) begin
      chk("post_rst_grant", 32'(req_ready), 32'h1);
      push(0, 2'b01, 1'b0, g + 1, 0);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
